pe_mac_sat: RTL and testbench

Parametrised systolic processing element for the weight/activation array. Performs multiply-accumulate over explicitly delimited tiles (`in_last`), supports stalls and signed or unsigned operands, and saturates the accumulator. Finished results go into a double buffer and leave through a ready/valid drain chain shared with upstream neighbours. Activations, weights and control are forwarded one cycle later to the next PE.

---
 rtl/pe_pkg.sv | 47 ++++
 rtl/pe_drain_slot.sv | 69 ++++++
 rtl/pe_mac_sat.sv | 141 ++++++++++++++
 tb/tb_pe_mac_sat.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the systolic MAC processing element.
// Saturation is done in a wide signed domain so one routine covers every ACC_W/SIGNED pair.
package pe_pkg;

    localparam int PE_MAX_W = 128;

    typedef logic signed [PE_MAX_W:0] pe_wide_t;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_ACC   = 1'b1
    } pe_state_e;

    function automatic pe_wide_t sat_hi(input int acc_w, input bit sgn);
        pe_wide_t one;
        one = pe_wide_t'(1);
        return sgn ? (one <<< (acc_w - 1)) - one : (one <<< acc_w) - one;
    endfunction

    function automatic pe_wide_t sat_lo(input int acc_w, input bit sgn);
        pe_wide_t one;
        one = pe_wide_t'(1);
        return sgn ? -(one <<< (acc_w - 1)) : '0;
    endfunction

    // Operands must already be extended according to their signedness.
    function automatic pe_wide_t sat_add(
        input  pe_wide_t a,
        input  pe_wide_t b,
        input  pe_wide_t hi,
        input  pe_wide_t lo,
        output logic     clamped
    );
        pe_wide_t s;
        s       = a + b;
        clamped = 1'b0;
        if (s > hi) begin
            s       = hi;
            clamped = 1'b1;
        end else if (s < lo) begin
            s       = lo;
            clamped = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/pe_drain_slot.sv
// Two-deep result storage (res_buf + output register) feeding the shared drain chain.
// Handshake: a word moves on out when o_res_valid & i_res_ready, and in when i_up_valid & o_up_ready.
module pe_drain_slot
    import pe_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_cap,
    input  logic [ACC_W-1:0] i_cap_data,
    input  logic [ACC_W-1:0] i_up_data,
    input  logic             i_up_valid,
    output logic             o_up_ready,
    output logic [ACC_W-1:0] o_res,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic             o_drop
);

    logic [ACC_W-1:0] r_buf;
    logic             r_buf_v;
    logic [ACC_W-1:0] r_out;
    logic             r_out_v;
    logic             w_slot_free;
    logic             w_buf_move;
    logic             w_drop;

    assign w_slot_free = !r_out_v || i_res_ready;
    assign w_buf_move  = w_slot_free && r_buf_v;
    // A capture is lost only when the buffer is full and cannot empty into the slot this cycle.
    assign w_drop      = i_cap && r_buf_v && !w_buf_move;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_buf   <= '0;
            r_buf_v <= 1'b0;
        end else if (i_cap && !w_drop) begin
            r_buf   <= i_cap_data;
            r_buf_v <= 1'b1;
        end else if (w_buf_move) begin
            r_buf_v <= 1'b0;
        end
    end

    // Local result takes priority over upstream traffic.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out   <= '0;
            r_out_v <= 1'b0;
        end else if (w_slot_free) begin
            if (r_buf_v) begin
                r_out   <= r_buf;
                r_out_v <= 1'b1;
            end else if (i_up_valid) begin
                r_out   <= i_up_data;
                r_out_v <= 1'b1;
            end else begin
                r_out_v <= 1'b0;
            end
        end
    end

    assign o_up_ready  = w_slot_free && !r_buf_v;
    assign o_res       = r_out;
    assign o_res_valid = r_out_v;
    assign o_drop      = w_drop;

endmodule

// File: rtl/pe_mac_sat.sv
// Systolic PE: tile-delimited saturating multiply-accumulate with operand forwarding.
// Finished tile results are handed to pe_drain_slot for the shared drain chain.
module pe_mac_sat
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_fire,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_w,
    output logic              out_fire,
    output logic              out_last,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_w,
    input  logic [ACC_W-1:0]  in_res,
    input  logic              in_res_valid,
    output logic              in_res_ready,
    output logic [ACC_W-1:0]  out_res,
    output logic              out_res_valid,
    input  logic              out_res_ready,
    output logic              sat_flag,
    output logic              overrun,
    output pe_state_e         o_dbg_state
);

    localparam pe_wide_t SAT_HI = sat_hi(ACC_W, SIGNED != 0);
    localparam pe_wide_t SAT_LO = sat_lo(ACC_W, SIGNED != 0);

    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_w_ext;
    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]    w_prod_acc;
    pe_wide_t            w_prod_x;
    pe_wide_t            w_acc_x;

    pe_state_e           r_state;
    pe_state_e           w_state_next;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_acc_next;
    logic                w_clamp;
    logic                w_cap;
    logic                w_drop;

    logic                r_fire;
    logic                r_last;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_w;
    logic                r_sat;
    logic                r_ovr;

    // Extending both operands to the product width makes one multiplier serve both signednesses.
    assign w_a_ext = (SIGNED != 0) ? {{DATA_W{in_a[DATA_W-1]}}, in_a} : {{DATA_W{1'b0}}, in_a};
    assign w_w_ext = (SIGNED != 0) ? {{DATA_W{in_w[DATA_W-1]}}, in_w} : {{DATA_W{1'b0}}, in_w};
    assign w_prod  = w_a_ext * w_w_ext;

    assign w_prod_acc = (SIGNED != 0) ? ACC_W'($signed(w_prod)) : ACC_W'(w_prod);
    assign w_prod_x   = (SIGNED != 0) ? pe_wide_t'($signed(w_prod)) : pe_wide_t'(w_prod);
    assign w_acc_x    = (SIGNED != 0) ? pe_wide_t'($signed(r_acc)) : pe_wide_t'(r_acc);

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_clamp      = 1'b0;
        if (in_fire) begin
            if (r_state == ST_FIRST) begin
                w_acc_next = w_prod_acc;
            end else begin
                w_acc_next = ACC_W'(sat_add(w_acc_x, w_prod_x, SAT_HI, SAT_LO, w_clamp));
            end
            w_state_next = in_last ? ST_FIRST : ST_ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_FIRST;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_fire <= 1'b0;
            r_last <= 1'b0;
            r_a    <= '0;
            r_w    <= '0;
        end else begin
            r_fire <= in_fire;
            r_last <= in_last;
            if (in_fire) begin
                r_a <= in_a;
                r_w <= in_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sat <= 1'b0;
            r_ovr <= 1'b0;
        end else begin
            r_sat <= r_sat || w_clamp;
            r_ovr <= r_ovr || w_drop;
        end
    end

    assign w_cap = in_fire && in_last;

    pe_drain_slot #(
        .ACC_W(ACC_W)
    ) u_drain (
        .clk        (clk),
        .rstn       (rstn),
        .i_cap      (w_cap),
        .i_cap_data (w_acc_next),
        .i_up_data  (in_res),
        .i_up_valid (in_res_valid),
        .o_up_ready (in_res_ready),
        .o_res      (out_res),
        .o_res_valid(out_res_valid),
        .i_res_ready(out_res_ready),
        .o_drop     (w_drop)
    );

    assign out_fire    = r_fire;
    assign out_last    = r_last;
    assign out_a       = r_a;
    assign out_w       = r_w;
    assign sat_flag    = r_sat;
    assign overrun     = r_ovr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pe_mac_sat.sv
// Bench for pe_mac_sat: three instances (signed/32, signed/16, unsigned/16) share one stimulus stream.
// Directed scenarios use constants; the random phase is scored against an arithmetic tile model.
module tb_pe_mac_sat;
    import pe_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        in_fire, in_last;
    logic [7:0]  in_a, in_w;
    logic [31:0] up_res;
    logic        in_res_valid, out_res_ready;

    logic        s32_fire, s32_last, s32_rdy, s32_v, s32_sat, s32_ovr;
    logic [7:0]  s32_a, s32_w;
    logic [31:0] s32_res;
    pe_state_e   s32_st;

    logic        s16_fire, s16_last, s16_rdy, s16_v, s16_sat, s16_ovr;
    logic [7:0]  s16_a, s16_w;
    logic [15:0] s16_res;
    pe_state_e   s16_st;

    logic        u16_fire, u16_last, u16_rdy, u16_v, u16_sat, u16_ovr;
    logic [7:0]  u16_a, u16_w;
    logic [15:0] u16_res;
    pe_state_e   u16_st;

    pe_mac_sat #(.DATA_W(8), .ACC_W(32), .SIGNED(1)) u_s32 (
        .clk(clk), .rstn(rstn), .in_fire(in_fire), .in_last(in_last), .in_a(in_a), .in_w(in_w),
        .out_fire(s32_fire), .out_last(s32_last), .out_a(s32_a), .out_w(s32_w),
        .in_res(up_res), .in_res_valid(in_res_valid), .in_res_ready(s32_rdy),
        .out_res(s32_res), .out_res_valid(s32_v), .out_res_ready(out_res_ready),
        .sat_flag(s32_sat), .overrun(s32_ovr), .o_dbg_state(s32_st)
    );

    pe_mac_sat #(.DATA_W(8), .ACC_W(16), .SIGNED(1)) u_s16 (
        .clk(clk), .rstn(rstn), .in_fire(in_fire), .in_last(in_last), .in_a(in_a), .in_w(in_w),
        .out_fire(s16_fire), .out_last(s16_last), .out_a(s16_a), .out_w(s16_w),
        .in_res(up_res[15:0]), .in_res_valid(in_res_valid), .in_res_ready(s16_rdy),
        .out_res(s16_res), .out_res_valid(s16_v), .out_res_ready(out_res_ready),
        .sat_flag(s16_sat), .overrun(s16_ovr), .o_dbg_state(s16_st)
    );

    pe_mac_sat #(.DATA_W(8), .ACC_W(16), .SIGNED(0)) u_u16 (
        .clk(clk), .rstn(rstn), .in_fire(in_fire), .in_last(in_last), .in_a(in_a), .in_w(in_w),
        .out_fire(u16_fire), .out_last(u16_last), .out_a(u16_a), .out_w(u16_w),
        .in_res(up_res[15:0]), .in_res_valid(in_res_valid), .in_res_ready(u16_rdy),
        .out_res(u16_res), .out_res_valid(u16_v), .out_res_ready(out_res_ready),
        .sat_flag(u16_sat), .overrun(u16_ovr), .o_dbg_state(u16_st)
    );

    // ---------------- scoreboard ----------------
    int n_total;
    int n_bad;

    longint      m_acc[3];
    bit          m_first[3];
    bit          m_sat[3];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] exp_q2[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_acc[k]   = 0;
            m_first[k] = 1'b1;
            m_sat[k]   = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
    endtask

    // Instance k: 0 = signed/32, 1 = signed/16, 2 = unsigned/16.
    task automatic model_pair(input int k, input logic [7:0] a, input logic [7:0] w, input logic l);
        longint p, hi, lo, t;
        int     aw;
        bit     sg;
        logic [31:0] v;
        aw = (k == 0) ? 32 : 16;
        sg = (k != 2);
        if (sg) p = longint'($signed(a)) * longint'($signed(w));
        else    p = longint'(a) * longint'(w);
        if (sg) begin
            hi = (longint'(1) <<< (aw - 1)) - 1;
            lo = -(longint'(1) <<< (aw - 1));
        end else begin
            hi = (longint'(1) <<< aw) - 1;
            lo = 0;
        end
        if (m_first[k]) begin
            m_acc[k] = p;
        end else begin
            m_acc[k] = m_acc[k] + p;
            if (m_acc[k] > hi) begin
                m_acc[k] = hi;
                m_sat[k] = 1'b1;
            end else if (m_acc[k] < lo) begin
                m_acc[k] = lo;
                m_sat[k] = 1'b1;
            end
        end
        if (l) begin
            t = m_acc[k];
            v = (aw == 32) ? t[31:0] : {16'h0, t[15:0]};
            case (k)
                0: exp_q0.push_back(v);
                1: exp_q1.push_back(v);
                default: exp_q2.push_back(v);
            endcase
            m_first[k] = 1'b1;
        end else begin
            m_first[k] = 1'b0;
        end
    endtask

    task automatic score(input int k, input logic v, input logic [31:0] res, input logic sat, input logic ovr);
        logic [31:0] e;
        int n;
        n = (k == 0) ? exp_q0.size() : (k == 1) ? exp_q1.size() : exp_q2.size();
        if (v) begin
            if (n == 0) begin
                chk($sformatf("extra_result%0d", k), v, 0);
            end else begin
                case (k)
                    0: e = exp_q0.pop_front();
                    1: e = exp_q1.pop_front();
                    default: e = exp_q2.pop_front();
                endcase
                chk($sformatf("rand_res%0d", k), res, e);
            end
        end
        chk($sformatf("rand_sat%0d", k), sat, m_sat[k]);
        chk($sformatf("rand_ovr%0d", k), ovr, 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic f, input logic l, input logic [7:0] a, input logic [7:0] w);
        in_fire = f;
        in_last = l;
        in_a    = a;
        in_w    = w;
        if (f) begin
            for (int k = 0; k < 3; k++) model_pair(k, a, w, l);
        end
        tick();
    endtask

    task automatic idle();
        in_fire = 1'b0;
        in_last = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        in_fire       = 1'b0;
        in_last       = 1'b0;
        in_a          = '0;
        in_w          = '0;
        in_res_valid  = 1'b0;
        up_res        = '0;
        out_res_ready = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
        model_clear();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] ra, rw, last_a;
        logic       rf, rl;
        n_total = 0;
        n_bad   = 0;
        model_clear();

        // reset values, sampled while reset is held
        rstn = 1'b0; in_fire = 1'b0; in_last = 1'b0; in_a = 8'h5a; in_w = 8'ha5;
        up_res = '0; in_res_valid = 1'b0; out_res_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_fire", s32_fire, 0);
        chk("rst_out_last", s32_last, 0);
        chk("rst_out_a", s32_a, 0);
        chk("rst_out_w", s32_w, 0);
        chk("rst_out_res", s32_res, 0);
        chk("rst_out_valid", s32_v, 0);
        chk("rst_sat", s32_sat, 0);
        chk("rst_ovr", s32_ovr, 0);
        chk("rst_in_ready", s32_rdy, 1);
        chk("rst_state", s32_st, ST_FIRST);
        rstn = 1'b1;

        // signed tile: 2*3 + (-4)*5 + 7*7 = 35
        put(1, 0, 8'd2, 8'd3);
        chk("fwd_a", s32_a, 2);
        chk("fwd_w", s32_w, 3);
        chk("fwd_fire", s32_fire, 1);
        chk("state_acc", s32_st, ST_ACC);
        put(1, 0, 8'hfc, 8'd5);
        put(1, 1, 8'd7, 8'd7);
        chk("fwd_last", s32_last, 1);
        chk("lat_edge_k_valid", s32_v, 0);
        idle();
        chk("lat_edge_k1_valid", s32_v, 1);
        chk("tile_res", s32_res, 35);
        idle();
        chk("valid_one_cycle", s32_v, 0);
        chk("tile_no_sat", s32_sat, 0);

        // stall mid-tile
        put(1, 0, 8'd2, 8'd3);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("stall_a", s32_a, 2);
            chk("stall_w", s32_w, 3);
            chk("stall_fire", s32_fire, 0);
        end
        put(1, 1, 8'd1, 8'd1);
        idle();
        chk("stall_res_valid", s32_v, 1);
        chk("stall_res", s32_res, 7);
        idle();

        // positive and negative saturation on the 16-bit instances
        do_reset();
        put(1, 0, 8'd127, 8'd127);
        put(1, 0, 8'd127, 8'd127);
        put(1, 1, 8'd127, 8'd127);
        idle();
        chk("satp_valid", s16_v, 1);
        chk("satp_res", s16_res, 16'h7fff);
        chk("satp_flag", s16_sat, 1);
        chk("satp_wide_res", s32_res, 48387);
        chk("satp_wide_flag", s32_sat, 0);
        idle();
        do_reset();
        put(1, 0, 8'h80, 8'd127);
        put(1, 0, 8'h80, 8'd127);
        put(1, 1, 8'h80, 8'd127);
        idle();
        chk("satn_res", s16_res, 16'h8000);
        chk("satn_flag", s16_sat, 1);
        chk("satn_wide_res", s32_res, 32'hffff4180);
        chk("satn_unsigned_res", u16_res, 48768);
        chk("satn_unsigned_flag", u16_sat, 0);
        idle();

        // drain ordering and backpressure
        do_reset();
        out_res_ready = 1'b0;
        put(1, 0, 8'd2, 8'd3);
        put(1, 0, 8'hfc, 8'd5);
        put(1, 1, 8'd7, 8'd7);
        idle();
        chk("bp_local_valid", s32_v, 1);
        up_res       = 32'd111;
        in_res_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("bp_res_hold", s32_res, 35);
            chk("bp_valid_hold", s32_v, 1);
            chk("bp_in_ready", s32_rdy, 0);
        end
        out_res_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", s32_rdy, 1);
        idle();
        chk("bp_upstream_res", s32_res, 111);
        chk("bp_upstream_valid", s32_v, 1);
        in_res_valid = 1'b0;
        idle();
        chk("bp_drained", s32_v, 0);

        // overrun: third undrained result is dropped
        do_reset();
        out_res_ready = 1'b0;
        put(1, 1, 8'd1, 8'd1);
        put(1, 1, 8'd2, 8'd2);
        chk("ovr_before", s32_ovr, 0);
        put(1, 1, 8'd3, 8'd3);
        chk("ovr_set", s32_ovr, 1);
        chk("ovr_head", s32_res, 1);
        idle();
        chk("ovr_head_hold", s32_res, 1);
        chk("ovr_in_ready", s32_rdy, 0);
        out_res_ready = 1'b1;
        idle();
        chk("ovr_second", s32_res, 4);
        chk("ovr_second_valid", s32_v, 1);
        idle();
        chk("ovr_no_third", s32_v, 0);
        idle();
        chk("ovr_no_third_late", s32_v, 0);
        chk("ovr_sticky", s32_ovr, 1);

        // reset in the middle of a tile
        do_reset();
        put(1, 0, 8'd5, 8'd5);
        chk("midrst_pre_a", s32_a, 5);
        rstn    = 1'b0;
        in_fire = 1'b0;
        in_last = 1'b0;
        tick();
        chk("midrst_out_a", s32_a, 0);
        chk("midrst_out_w", s32_w, 0);
        chk("midrst_out_fire", s32_fire, 0);
        chk("midrst_valid", s32_v, 0);
        chk("midrst_state", s32_st, ST_FIRST);
        rstn = 1'b1;
        put(1, 1, 8'd1, 8'd2);
        idle();
        chk("midrst_res_valid", s32_v, 1);
        chk("midrst_res", s32_res, 2);
        idle();

        // randomized tiles with stalls, scored against the tile model
        do_reset();
        last_a = '0;
        for (int c = 0; c < 600; c++) begin
            rf = ($urandom_range(0, 3) != 0);
            rl = ($urandom_range(0, 3) == 0);
            ra = 8'($urandom);
            rw = 8'($urandom);
            if (rf) last_a = ra;
            put(rf, rl, ra, rw);
            chk("rand_fwd_a", s32_a, last_a);
            score(0, s32_v, s32_res, s32_sat, s32_ovr);
            score(1, s16_v, {16'h0, s16_res}, s16_sat, s16_ovr);
            score(2, u16_v, {16'h0, u16_res}, u16_sat, u16_ovr);
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            score(0, s32_v, s32_res, s32_sat, s32_ovr);
            score(1, s16_v, {16'h0, s16_res}, s16_sat, s16_ovr);
            score(2, u16_v, {16'h0, u16_res}, u16_sat, u16_ovr);
        end
        chk("rand_left0", exp_q0.size(), 0);
        chk("rand_left1", exp_q1.size(), 0);
        chk("rand_left2", exp_q2.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
